// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: colour codes, storage depth
// and the sequence player state encoding.
package simon_pkg;

  localparam logic [2:0] RED        = 3'b000;
  localparam logic [2:0] GREEN      = 3'b001;
  localparam logic [2:0] BLUE       = 3'b010;
  localparam logic [2:0] YELLOW     = 3'b011;
  localparam logic [2:0] UNASSIGNED = 3'b100;

  localparam int DEPTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ON    = 3'd2,
    ST_OFF   = 3'd3,
    ST_DONE  = 3'd4
  } player_state_e;

endpackage

// File: rtl/sequence_player_if.sv
// Control, segments-array read port and lamp outputs of the sequence player.
// The master side is the surrounding game; the slave side is the player.
interface sequence_player_if #(
  parameter int DEPTH = simon_pkg::DEPTH
);
  localparam int IW = $clog2(DEPTH);

  logic          start;
  logic          abort;
  logic [IW:0]   seq_len;
  logic [IW-1:0] rd_index;
  logic [2:0]    rd_colour;
  logic [2:0]    colour_out;
  logic          lamp_on;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, abort, seq_len, rd_colour,
    input  rd_index, colour_out, lamp_on, busy, done, err
  );

  modport slave (
    input  start, abort, seq_len, rd_colour,
    output rd_index, colour_out, lamp_on, busy, done, err
  );

endinterface

// File: rtl/down_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count stops at zero.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != {WIDTH{1'b0}})) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/sequence_player.sv
// Replays the stored colour sequence on the lamps, oldest slot first, with
// fixed lit and dark intervals per colour.
module sequence_player #(
  parameter int DEPTH      = simon_pkg::DEPTH,
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000
) (
  input logic              clk,
  input logic              reset,
  sequence_player_if.slave bus
);
  import simon_pkg::*;

  localparam int IW   = $clog2(DEPTH);
  localparam int LW   = IW + 1;
  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  player_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    colour_q, colour_d;
  logic          err_q, err_d;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_dec;
  logic          t_zero;
  logic [LW-1:0] len_c;

  // Requests longer than the array replay the whole array.
  assign len_c = (bus.seq_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.seq_len;

  down_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    colour_d = colour_q;
    err_d    = err_q;
    t_load   = 1'b0;
    t_val    = {TW{1'b0}};
    t_dec    = 1'b0;
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            err_d = 1'b0;
            if (len_c != {LW{1'b0}}) begin
              idx_d   = IW'(len_c - LW'(1));
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          colour_d = bus.rd_colour;
          if (bus.rd_colour[2]) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            t_load  = 1'b1;
            t_val   = TW'(ON_CYCLES - 1);
            state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (t_zero) begin
            t_load  = 1'b1;
            t_val   = TW'(OFF_CYCLES - 1);
            state_d = ST_OFF;
          end else begin
            t_dec = 1'b1;
          end
        end
        ST_OFF: begin
          if (!t_zero) begin
            t_dec = 1'b1;
          end else if (idx_q == {IW{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = ST_FETCH;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= {IW{1'b0}};
      colour_q <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      colour_q <= colour_d;
      err_q    <= err_d;
    end
  end

  assign bus.rd_index   = idx_q;
  assign bus.colour_out = colour_q;
  assign bus.err        = err_q;
  assign bus.lamp_on    = (state_q == ST_ON);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: directed scenarios plus random sequences, all
// compared cycle by cycle against a timeline built from the playback rules.
module tb_sequence_player;
  import simon_pkg::*;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int D   = 32;

  typedef struct packed {
    logic       busy;
    logic       lamp;
    logic       done;
    logic       err;
    logic [2:0] colour;
    logic [4:0] idx;
  } exp_t;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  logic [2:0] mem [D];
  exp_t   trace[$];
  exp_t   last_e;
  int     n_tests = 0;
  int     n_fail  = 0;

  sequence_player_if #(.DEPTH(D)) bus ();

  assign bus.rd_colour = mem[bus.rd_index];

  sequence_player #(
    .DEPTH      (D),
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_entry(input exp_t e);
    check_eq("busy",       32'(bus.busy),       32'(e.busy));
    check_eq("lamp_on",    32'(bus.lamp_on),    32'(e.lamp));
    check_eq("done",       32'(bus.done),       32'(e.done));
    check_eq("err",        32'(bus.err),        32'(e.err));
    check_eq("colour_out", 32'(bus.colour_out), 32'(e.colour));
    check_eq("rd_index",   32'(bus.rd_index),   32'(e.idx));
  endtask

  // Timeline of outputs for each cycle after an accepted start, from the
  // current slot contents: newest-last replay, fetch + ON lit + OFF dark each.
  task automatic build(input int len);
    int         l;
    exp_t       e;
    logic [2:0] col;
    bit         bad;
    l   = (len > D) ? D : len;
    col = last_e.colour;
    bad = 1'b0;
    trace.delete();
    e        = last_e;
    e.busy   = 1'b1;
    e.err    = 1'b0;
    for (int i = l - 1; i >= 0 && !bad; i--) begin
      e.lamp   = 1'b0;
      e.done   = 1'b0;
      e.idx    = 5'(i);
      e.colour = col;
      trace.push_back(e);
      col      = mem[i];
      e.colour = col;
      if (col[2]) begin
        bad   = 1'b1;
        e.err = 1'b1;
      end else begin
        e.lamp = 1'b1;
        repeat (ON) trace.push_back(e);
        e.lamp = 1'b0;
        repeat (OFF) trace.push_back(e);
      end
    end
    e.lamp = 1'b0;
    e.done = 1'b1;
    trace.push_back(e);
  endtask

  task automatic run(input int len, input int abort_at, input int spur_at, input bit rnd_spur);
    bus.start   = 1'b1;
    bus.seq_len = 6'(len);
    build(len);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.seq_len = 6'($urandom);
    for (int k = 0; k < trace.size(); k++) begin
      check_entry(trace[k]);
      last_e    = trace[k];
      bus.abort = (k == abort_at);
      bus.start = (k == spur_at) || (rnd_spur && ($urandom_range(0, 7) == 0));
      @(posedge clk); #1;
      bus.abort = 1'b0;
      bus.start = 1'b0;
      if (k == abort_at) break;
    end
    last_e.busy = 1'b0;
    last_e.lamp = 1'b0;
    last_e.done = 1'b0;
    check_entry(last_e);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_entry(last_e);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.seq_len = 6'd0;
    for (int i = 0; i < D; i++) mem[i] = RED;
    last_e = '0;

    #1;
    check_entry(last_e);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_entry(last_e);

    mem[0] = RED; mem[1] = BLUE; mem[2] = GREEN;
    run(3, -1, -1, 1'b0);
    run(0, -1, -1, 1'b0);
    mem[1] = UNASSIGNED;
    run(2, -1, -1, 1'b0);
    mem[1] = BLUE;
    run(2, -1, -1, 1'b0);
    run(3, 2, -1, 1'b0);
    run(3, -1, -1, 1'b0);
    run(3, -1, 3, 1'b0);
    mem[31] = YELLOW;
    run(40, -1, -1, 1'b0);

    // Asynchronous reset in the middle of a dark gap.
    bus.start   = 1'b1;
    bus.seq_len = 6'd3;
    build(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_entry(trace[0]);
    repeat (5) @(posedge clk);
    #1;
    check_entry(trace[5]);
    #2;
    reset = 1'b1;
    #1;
    last_e = '0;
    check_entry(last_e);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_entry(last_e);
    end

    for (int r = 0; r < 50; r++) begin
      int len;
      int ab;
      for (int i = 0; i < D; i++) begin
        mem[i] = ((r % 2 == 1) && ($urandom_range(0, 9) == 0)) ? UNASSIGNED
                                                               : {1'b0, 2'($urandom)};
      end
      len = $urandom_range(0, 40);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
      run(len, ab, -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
